// File: rtl/npe_pkg.sv
// Shared constants and lane helpers for the NPE result requantiser.
// Saturation bounds and accumulator width default to the 8-bit output lane.
package npe_pkg;

    localparam int NPE_DATA_W = 8;
    localparam int NPE_ACC_W  = 2 * NPE_DATA_W;
    localparam int QMAX       = 127;
    localparam int QMIN       = -128;

    function automatic int lane_lsb(input int lane, input int lane_w);
        return lane * lane_w;
    endfunction

    function automatic int acc_width(input int data_w);
        return (data_w == NPE_DATA_W) ? NPE_ACC_W : 2 * data_w;
    endfunction

    function automatic int sat_max(input int data_w);
        return (data_w == NPE_DATA_W) ? QMAX : (1 << (data_w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int data_w);
        return (data_w == NPE_DATA_W) ? QMIN : -(1 << (data_w - 1));
    endfunction

endpackage

// File: rtl/npe_sync_fifo.sv
// First-word-fall-through synchronous FIFO: the head entry is always visible on rd_data.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module npe_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wr_data,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = cnt;
    // Empty reads as zero so the output is clean after reset and between bursts.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/npe_result_requant.sv
// Requantises NPE result beats: per-lane bias add, rounded arithmetic shift, optional ReLU,
// saturation to signed DATA_WIDTH, then buffering in a FWFT FIFO toward the output writer.
module npe_result_requant
    import npe_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_COPIES = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [DATA_COPIES*2*DATA_WIDTH-1:0] i_npe_result,
    input  logic                                i_npe_result_vld,
    input  logic [DATA_COPIES*2*DATA_WIDTH-1:0] i_bias,
    input  logic                                i_bias_en,
    input  logic [SHIFT_WIDTH-1:0]              i_shift,
    input  logic                                i_relu_en,
    output logic [DATA_COPIES*DATA_WIDTH-1:0]   o_odata,
    output logic                                o_odata_vld,
    input  logic                                i_odata_rdy,
    output logic                                o_fifo_full,
    output logic                                o_overflow,
    input  logic                                i_ovf_clear,
    output logic                                o_busy
);

    localparam int ACC_W  = acc_width(DATA_WIDTH);
    localparam int SUM_W  = ACC_W + 1;
    localparam int RND_W  = SUM_W + 1;
    localparam int OUT_W  = DATA_COPIES * DATA_WIDTH;
    localparam int SAT_HI = sat_max(DATA_WIDTH);
    localparam int SAT_LO = sat_min(DATA_WIDTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    logic [DATA_COPIES*SUM_W-1:0] sum_d;
    logic [DATA_COPIES*SUM_W-1:0] s1_sum;
    logic [SHIFT_WIDTH-1:0]       s1_shift;
    logic                         s1_relu;
    logic                         s1_vld;
    logic [OUT_W-1:0]             q_d;
    logic [OUT_W-1:0]             s2_q;
    logic                         s2_vld;

    logic                         fifo_full;
    logic                         fifo_empty;
    logic [CNT_W-1:0]             fifo_count;
    logic                         drop;

    for (genvar k = 0; k < DATA_COPIES; k++) begin : g_lane
        logic signed [ACC_W-1:0] res_l;
        logic signed [ACC_W-1:0] bias_l;
        logic signed [SUM_W-1:0] s1_l;
        logic signed [RND_W-1:0] ext_l;
        logic signed [RND_W-1:0] rnd_l;
        logic signed [RND_W-1:0] shifted_l;
        logic [DATA_WIDTH-1:0]   q_l;

        assign res_l  = i_npe_result[lane_lsb(k, ACC_W) +: ACC_W];
        assign bias_l = i_bias_en ? i_bias[lane_lsb(k, ACC_W) +: ACC_W] : '0;
        assign sum_d[lane_lsb(k, SUM_W) +: SUM_W] = SUM_W'(res_l) + SUM_W'(bias_l);
        assign s1_l   = s1_sum[lane_lsb(k, SUM_W) +: SUM_W];

        // Shifts of SUM_W or more always round to zero for any 17-bit sum, so they are
        // short-circuited and the rounding path only needs one guard bit.
        always_comb begin
            ext_l     = RND_W'(s1_l);
            rnd_l     = '0;
            if (s1_shift != '0) begin
                rnd_l = RND_W'(1) <<< (s1_shift - SHIFT_WIDTH'(1));
            end
            shifted_l = (ext_l + rnd_l) >>> s1_shift;
            if (int'(s1_shift) >= SUM_W) begin
                shifted_l = '0;
            end
            if (s1_relu && (shifted_l < 0)) begin
                shifted_l = '0;
            end
            if (shifted_l > RND_W'(SAT_HI)) begin
                q_l = DATA_WIDTH'(SAT_HI);
            end else if (shifted_l < RND_W'(SAT_LO)) begin
                q_l = DATA_WIDTH'(SAT_LO);
            end else begin
                q_l = shifted_l[DATA_WIDTH-1:0];
            end
        end

        assign q_d[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = q_l;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            s1_vld <= i_npe_result_vld;
            s2_vld <= s1_vld;
        end
    end

    // Config travels with its beat, so it may change freely between beats.
    always_ff @(posedge i_clk) begin
        if (i_npe_result_vld) begin
            s1_sum   <= sum_d;
            s1_shift <= i_shift;
            s1_relu  <= i_relu_en;
        end
        if (s1_vld) begin
            s2_q <= q_d;
        end
    end

    npe_sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .push    (s2_vld),
        .pop     (i_odata_rdy),
        .wr_data (s2_q),
        .rd_data (o_odata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // A full FIFO is never empty, so rdy alone tells whether a slot frees this cycle.
    assign drop = s2_vld && fifo_full && !i_odata_rdy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overflow <= 1'b0;
        end else if (drop) begin
            o_overflow <= 1'b1;
        end else if (i_ovf_clear) begin
            o_overflow <= 1'b0;
        end
    end

    assign o_odata_vld = !fifo_empty;
    assign o_fifo_full = fifo_full;
    assign o_busy      = s1_vld || s2_vld || (fifo_count != '0);

endmodule

// File: tb/tb_npe_result_requant.sv
// Scoreboard bench for npe_result_requant: directed corner cases followed by random traffic,
// checked against an arithmetic reference model and a queue model of the output FIFO.
`timescale 1ns/1ps
module tb_npe_result_requant;

    localparam int LANES = 32;
    localparam int IN_W  = LANES * 16;
    localparam int OUT_W = LANES * 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [IN_W-1:0]  npe_result = '0;
    logic             npe_result_vld = 1'b0;
    logic [IN_W-1:0]  bias = '0;
    logic             bias_en = 1'b0;
    logic [4:0]       shift = '0;
    logic             relu_en = 1'b0;
    logic [OUT_W-1:0] odata;
    logic             odata_vld;
    logic             odata_rdy = 1'b0;
    logic             fifo_full;
    logic             overflow;
    logic             ovf_clear = 1'b0;
    logic             busy;

    typedef struct {
        logic [OUT_W-1:0] data;
        int               arrive;
    } pend_t;

    pend_t            pending[$];
    logic [OUT_W-1:0] model_fifo[$];
    logic             model_ovf = 1'b0;
    int               cyc = 0;
    int               n_checks = 0;
    int               n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    npe_result_requant dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_npe_result     (npe_result),
        .i_npe_result_vld (npe_result_vld),
        .i_bias           (bias),
        .i_bias_en        (bias_en),
        .i_shift          (shift),
        .i_relu_en        (relu_en),
        .o_odata          (odata),
        .o_odata_vld      (odata_vld),
        .i_odata_rdy      (odata_rdy),
        .o_fifo_full      (fifo_full),
        .o_overflow       (overflow),
        .i_ovf_clear      (ovf_clear),
        .o_busy           (busy)
    );

    function automatic logic [7:0] quantise_lane(input int res, input int b, input bit ben,
                                                 input int sh, input bit relu);
        longint sum;
        longint q;
        sum = longint'(res) + (ben ? longint'(b) : 64'sd0);
        if (sh == 0) q = sum;
        else         q = (sum + (longint'(1) << (sh - 1))) >>> sh;
        if (relu && q < 0) q = 0;
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return q[7:0];
    endfunction

    function automatic logic [OUT_W-1:0] expected_beat(input logic [IN_W-1:0] res_v,
                                                       input logic [IN_W-1:0] bias_v,
                                                       input logic ben, input logic [4:0] sh,
                                                       input logic relu);
        logic [OUT_W-1:0]   beat;
        logic signed [15:0] r16;
        logic signed [15:0] b16;
        beat = '0;
        for (int k = 0; k < LANES; k++) begin
            r16 = res_v[16*k +: 16];
            b16 = bias_v[16*k +: 16];
            beat[8*k +: 8] = quantise_lane(int'(r16), int'(b16), ben, int'(sh), relu);
        end
        return beat;
    endfunction

    function automatic logic [IN_W-1:0] rand_vec();
        logic [IN_W-1:0] v;
        for (int w = 0; w < IN_W / 32; w++) v[32*w +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [263:0] act, input logic [263:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic vld, input logic [IN_W-1:0] res,
                                  input logic [IN_W-1:0] b, input logic ben, input logic [4:0] sh,
                                  input logic relu, input logic rdy, input logic clr);
        @(posedge clk);
        #1;
        npe_result     = res;
        npe_result_vld = vld;
        bias           = b;
        bias_en        = ben;
        shift          = sh;
        relu_en        = relu;
        odata_rdy      = rdy;
        ovf_clear      = clr;
        if (vld) pending.push_back('{expected_beat(res, b, ben, sh, relu), cyc + 3});
    endtask

    task automatic idle(input logic rdy, input logic clr);
        apply_stimulus(1'b0, '0, '0, 1'b0, 5'd0, 1'b0, rdy, clr);
    endtask

    // Monitor: compares DUT state after each edge, then advances the model across the next edge.
    always @(negedge clk) begin : monitor
        logic pop;
        logic drop;
        logic exp_busy;
        pend_t p;
        if (!rst_n) begin
            check_output("reset_state", {odata_vld, fifo_full, overflow, busy, odata}, '0);
            pending.delete();
            model_fifo.delete();
            model_ovf = 1'b0;
        end else begin
            exp_busy = (model_fifo.size() != 0) ||
                       (pending.size() != 0 && pending[0].arrive <= cyc + 2);
            check_output("odata_vld", odata_vld, model_fifo.size() != 0);
            check_output("fifo_full", fifo_full, model_fifo.size() == DEPTH);
            check_output("overflow", overflow, model_ovf);
            check_output("busy", busy, exp_busy);
            if (model_fifo.size() != 0) check_output("odata", odata, model_fifo[0]);
            pop  = (model_fifo.size() != 0) && odata_rdy;
            drop = 1'b0;
            if (pop) void'(model_fifo.pop_front());
            if (pending.size() != 0 && pending[0].arrive == cyc + 1) begin
                p = pending.pop_front();
                if (model_fifo.size() < DEPTH) model_fifo.push_back(p.data);
                else                           drop = 1'b1;
            end
            if (drop)           model_ovf = 1'b1;
            else if (ovf_clear) model_ovf = 1'b0;
        end
    end

    initial begin : stimulus
        logic [IN_W-1:0] rv;
        logic [IN_W-1:0] bv;
        logic            v;
        logic            rdy;
        logic            clr;
        logic [4:0]      sh;
        int              t0;
        int              lat;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] T1 basic shift and latency");
        rv = '0;
        rv[15:0] = 16'h0100;
        apply_stimulus(1'b1, rv, '0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0);
        t0  = cyc;
        lat = -1;
        for (int i = 0; i < 8; i++) begin
            idle(1'b0, 1'b0);
            @(negedge clk);
            if (odata_vld) begin
                lat = cyc - t0;
                break;
            end
        end
        check_output("t1_latency", lat, 3);
        check_output("t1_lane0", odata[7:0], 8'h40);
        repeat (3) idle(1'b1, 1'b0);

        $display("[TB] T2 bias, rounding and relu");
        rv = '0;
        bv = '0;
        rv[15:0] = 16'h0005;
        bv[15:0] = 16'hFFF0;
        apply_stimulus(1'b1, rv, bv, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, rv, bv, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0);
        repeat (4) idle(1'b1, 1'b0);

        $display("[TB] T3 saturation");
        rv = '0;
        rv[15:0]  = 16'h7FFF;
        rv[31:16] = 16'h8000;
        rv[47:32] = 16'h0003;
        apply_stimulus(1'b1, rv, '0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, rv, '0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0);
        repeat (4) idle(1'b1, 1'b0);

        $display("[TB] T4 overflow with stalled consumer");
        for (int i = 0; i < 6; i++)
            apply_stimulus(1'b1, rand_vec(), rand_vec(), 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        repeat (3) idle(1'b0, 1'b0);
        @(negedge clk);
        check_output("t4_full", fifo_full, 1'b1);
        check_output("t4_overflow_set", overflow, 1'b1);
        repeat (5) idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);
        @(negedge clk);
        check_output("t4_overflow_cleared", overflow, 1'b0);

        $display("[TB] T5 push into full FIFO with simultaneous pop");
        for (int i = 0; i < 5; i++)
            apply_stimulus(1'b1, rand_vec(), '0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);
        @(negedge clk);
        check_output("t5_still_full", fifo_full, 1'b1);
        check_output("t5_no_overflow", overflow, 1'b0);
        repeat (6) idle(1'b1, 1'b0);

        $display("[TB] T6 reset with beats in flight");
        for (int i = 0; i < 5; i++)
            apply_stimulus(1'b1, rand_vec(), rand_vec(), 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) idle(1'b1, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(0, 99) < 60);
            rdy = ($urandom_range(0, 99) < 75);
            clr = ($urandom_range(0, 99) < 3);
            sh  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(4, 10));
            apply_stimulus(v, rand_vec(), rand_vec(), 1'($urandom_range(0, 1)), sh,
                           1'($urandom_range(0, 1)), rdy, clr);
        end

        for (int i = 0; i < 50 && (model_fifo.size() != 0 || pending.size() != 0); i++)
            idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        @(negedge clk);
        check_output("drained", {busy, odata_vld}, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
